// File: rtl/recovery_sequencer_pkg.sv
// Shared phase encodings, refetch types and the ActiveList age helper for the
// recovery sequencer.
package RecoverySequencerTypes;

  localparam logic [1:0] PH_COMMIT    = 2'd0;
  localparam logic [1:0] PH_RECOVER_0 = 2'd1;
  localparam logic [1:0] PH_RECOVER_1 = 2'd2;
  localparam logic [1:0] PH_CSR_WAIT  = 2'd3;

  typedef enum logic [2:0] {
    RT_THIS_PC        = 3'd0,
    RT_NEXT_PC        = 3'd1,
    RT_BRANCH_TARGET  = 3'd2,
    RT_THIS_PC_TO_CSR = 3'd3,
    RT_NEXT_PC_TO_CSR = 3'd4
  } refetch_e;

  // Distance from head, modulo 2^w; smaller means older.
  function automatic logic [31:0] age_of(input logic [31:0] ptr, input logic [31:0] head,
                                         input int unsigned w);
    logic [31:0] d;
    d = ptr - head;
    if (w < 32) d = d & ((32'd1 << w) - 32'd1);
    return d;
  endfunction

  function automatic logic is_csr_type(input logic [2:0] t);
    return (t == RT_THIS_PC_TO_CSR) || (t == RT_NEXT_PC_TO_CSR);
  endfunction

endpackage

// File: rtl/recovery_sequencer_age_arbiter.sv
// Combinational oldest-first selector across recovery request channels.
module recovery_age_arbiter
  import RecoverySequencerTypes::*;
#(
  parameter int NUM_SOURCES = 2,
  parameter int PTR_WIDTH   = 6,
  parameter int PC_WIDTH    = 32,
  parameter int SRC_W       = 1
) (
  input  logic [NUM_SOURCES-1:0]           i_req_valid,
  input  logic [NUM_SOURCES*PTR_WIDTH-1:0] i_req_ptr,
  input  logic [NUM_SOURCES*PC_WIDTH-1:0]  i_req_pc,
  input  logic [NUM_SOURCES*3-1:0]         i_req_type,
  input  logic [PTR_WIDTH-1:0]             i_head_ptr,
  output logic                             o_grant_valid,
  output logic [SRC_W-1:0]                 o_grant_idx,
  output logic [PTR_WIDTH-1:0]             o_grant_ptr,
  output logic [PC_WIDTH-1:0]              o_grant_pc,
  output logic [2:0]                       o_grant_type
);

  logic [31:0] w_age;
  logic [31:0] w_best;

  // Strict less-than keeps the lowest index on equal ages.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    o_grant_ptr   = '0;
    o_grant_pc    = '0;
    o_grant_type  = '0;
    w_best        = '1;
    w_age         = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      w_age = age_of(32'(i_req_ptr[i*PTR_WIDTH +: PTR_WIDTH]), 32'(i_head_ptr), PTR_WIDTH);
      if (i_req_valid[i] && (!o_grant_valid || w_age < w_best)) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = SRC_W'(i);
        o_grant_ptr   = i_req_ptr[i*PTR_WIDTH +: PTR_WIDTH];
        o_grant_pc    = i_req_pc[i*PC_WIDTH +: PC_WIDTH];
        o_grant_type  = i_req_type[i*3 +: 3];
        w_best        = w_age;
      end
    end
  end

endmodule

// File: rtl/recovery_sequencer.sv
// Recovery controller: accepts the oldest recovery request, runs the optional
// CSR trap handshake, broadcasts refetch PC / flush range and waits out busy units.
module recovery_sequencer
  import RecoverySequencerTypes::*;
#(
  parameter int NUM_SOURCES   = 2,
  parameter int PTR_WIDTH     = 6,
  parameter int PC_WIDTH      = 32,
  parameter int NUM_WAIT      = 4,
  parameter int MIN_R1_CYCLES = 1,
  parameter int MAX_WAIT      = 255,
  parameter int INSN_BYTES    = 4,
  localparam int SRC_W        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SOURCES-1:0]           req_valid,
  input  logic [NUM_SOURCES*PTR_WIDTH-1:0] req_ptr,
  input  logic [NUM_SOURCES*PC_WIDTH-1:0]  req_pc,
  input  logic [NUM_SOURCES*3-1:0]         req_type,
  input  logic [PTR_WIDTH-1:0]             al_head_ptr,
  input  logic [PTR_WIDTH-1:0]             al_tail_ptr,
  input  logic [NUM_WAIT-1:0]              busy,
  output logic                             csr_trap_req,
  output logic [PC_WIDTH-1:0]              csr_cause_pc,
  input  logic                             csr_trap_ack,
  input  logic [PC_WIDTH-1:0]              csr_target_pc,
  output logic [1:0]                       phase,
  output logic                             recovery_start,
  output logic [PC_WIDTH-1:0]              recovered_pc,
  output logic [PTR_WIDTH-1:0]             flush_head_ptr,
  output logic [PTR_WIDTH-1:0]             flush_tail_ptr,
  output logic [SRC_W-1:0]                 winner_src,
  output logic                             unable_to_start,
  output logic                             recovery_done,
  output logic                             timeout_err
);

  typedef struct packed {
    logic [PTR_WIDTH-1:0] ptr;
    logic [PC_WIDTH-1:0]  pc;
    logic [2:0]           rtype;
    logic [SRC_W-1:0]     src;
    logic [PTR_WIDTH-1:0] tail;
  } lat_req_t;

  logic [1:0]           r_phase;
  lat_req_t             r_lat;
  logic [PC_WIDTH-1:0]  r_target;
  logic [7:0]           r_r1cnt;
  logic                 r_timeout;

  logic                 w_g_valid;
  logic [SRC_W-1:0]     w_g_idx;
  logic [PTR_WIDTH-1:0] w_g_ptr;
  logic [PC_WIDTH-1:0]  w_g_pc;
  logic [2:0]           w_g_type;
  logic [2:0]           w_norm_type;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_active;
  logic                 w_this;

  recovery_age_arbiter #(
    .NUM_SOURCES(NUM_SOURCES), .PTR_WIDTH(PTR_WIDTH), .PC_WIDTH(PC_WIDTH), .SRC_W(SRC_W)
  ) u_arb (
    .i_req_valid(req_valid), .i_req_ptr(req_ptr), .i_req_pc(req_pc), .i_req_type(req_type),
    .i_head_ptr(al_head_ptr), .o_grant_valid(w_g_valid), .o_grant_idx(w_g_idx),
    .o_grant_ptr(w_g_ptr), .o_grant_pc(w_g_pc), .o_grant_type(w_g_type)
  );

  assign w_norm_type     = (w_g_type > 3'd4) ? RT_THIS_PC : w_g_type;
  assign w_active        = (r_phase != PH_COMMIT);
  assign unable_to_start = w_active | (|busy);
  assign w_accept        = ~unable_to_start & w_g_valid;
  assign w_done          = (r_phase == PH_RECOVER_1) && (r_r1cnt >= 8'(MIN_R1_CYCLES)) && !(|busy);
  assign w_this          = (r_lat.rtype == RT_THIS_PC) || (r_lat.rtype == RT_THIS_PC_TO_CSR);

  assign phase          = r_phase;
  assign recovery_start = (r_phase == PH_RECOVER_0);
  assign recovery_done  = w_done;
  assign timeout_err    = r_timeout;
  assign csr_trap_req   = (r_phase == PH_CSR_WAIT);
  assign csr_cause_pc   = csr_trap_req ? r_lat.pc : '0;
  assign flush_head_ptr = !w_active ? '0 : (w_this ? r_lat.ptr : r_lat.ptr + PTR_WIDTH'(1));
  assign flush_tail_ptr = w_active ? r_lat.tail : '0;
  assign winner_src     = w_active ? r_lat.src : '0;

  always_comb begin
    recovered_pc = '0;
    if (recovery_start) begin
      if (is_csr_type(r_lat.rtype))        recovered_pc = r_target;
      else if (r_lat.rtype == RT_NEXT_PC)  recovered_pc = r_lat.pc + PC_WIDTH'(INSN_BYTES);
      else                                 recovered_pc = r_lat.pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase   <= PH_COMMIT;
      r_lat     <= '0;
      r_target  <= '0;
      r_r1cnt   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_phase)
        PH_COMMIT: if (w_accept) begin
          r_lat   <= '{ptr: w_g_ptr, pc: w_g_pc, rtype: w_norm_type, src: w_g_idx, tail: al_tail_ptr};
          r_phase <= is_csr_type(w_norm_type) ? PH_CSR_WAIT : PH_RECOVER_0;
        end
        PH_CSR_WAIT: if (csr_trap_ack) begin
          r_target <= csr_target_pc;
          r_phase  <= PH_RECOVER_0;
        end
        PH_RECOVER_0: begin
          r_phase <= PH_RECOVER_1;
          r_r1cnt <= 8'd1;
        end
        default: begin
          if (w_done) r_phase <= PH_COMMIT;
          else if (r_r1cnt < 8'(MAX_WAIT)) r_r1cnt <= r_r1cnt + 8'd1;
          if (r_r1cnt == 8'(MAX_WAIT) && (|busy)) r_timeout <= 1'b1;
        end
      endcase
    end
  end

  // Acceptance happens only in COMMIT and done only in RECOVER_1, so they never overlap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_accept) begin
        assert (w_g_type <= 3'd4);
        assert (!is_csr_type(w_g_type) || w_g_idx == '0);
      end
      assert (!(w_accept && w_done));
    end
  end

endmodule

// File: tb/tb_recovery_sequencer.sv
// Directed bench for recovery_sequencer with a scoreboard of expected recovery broadcasts.
module tb_recovery_sequencer;
  localparam int NS = 2, PW = 6, CW = 32, NW = 4;

  logic           clk = 1'b0, rst = 1'b1;
  logic [NS-1:0]  req_valid = '0;
  logic [NS*PW-1:0] req_ptr = '0;
  logic [NS*CW-1:0] req_pc = '0;
  logic [NS*3-1:0]  req_type = '0;
  logic [PW-1:0]  al_head_ptr = '0, al_tail_ptr = '0;
  logic [NW-1:0]  busy = '0;
  logic           csr_trap_req, csr_trap_ack = 1'b0;
  logic [CW-1:0]  csr_cause_pc, csr_target_pc = '0, recovered_pc;
  logic [1:0]     phase;
  logic           recovery_start, unable_to_start, recovery_done, timeout_err;
  logic [PW-1:0]  flush_head_ptr, flush_tail_ptr;
  logic           winner_src;

  always #5 clk = ~clk;

  recovery_sequencer #(
    .NUM_SOURCES(NS), .PTR_WIDTH(PW), .PC_WIDTH(CW), .NUM_WAIT(NW),
    .MIN_R1_CYCLES(1), .MAX_WAIT(8), .INSN_BYTES(4)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ptr(req_ptr), .req_pc(req_pc),
    .req_type(req_type), .al_head_ptr(al_head_ptr), .al_tail_ptr(al_tail_ptr), .busy(busy),
    .csr_trap_req(csr_trap_req), .csr_cause_pc(csr_cause_pc), .csr_trap_ack(csr_trap_ack),
    .csr_target_pc(csr_target_pc), .phase(phase), .recovery_start(recovery_start),
    .recovered_pc(recovered_pc), .flush_head_ptr(flush_head_ptr), .flush_tail_ptr(flush_tail_ptr),
    .winner_src(winner_src), .unable_to_start(unable_to_start), .recovery_done(recovery_done),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  fh;
    logic [5:0]  ft;
    logic        src;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int s, input int ptr, input int pc, input int t);
    req_valid[s]            = 1'b1;
    req_ptr[s*PW +: PW]     = PW'(ptr);
    req_pc[s*CW +: CW]      = CW'(pc);
    req_type[s*3 +: 3]      = 3'(t);
  endtask

  task automatic push(input int pc, input int fh, input int ft, input int src);
    exp_t e;
    e.pc = 32'(pc); e.fh = 6'(fh); e.ft = 6'(ft); e.src = 1'(src);
    sb.push_back(e);
  endtask

  // Bounded wait for the RECOVER_0 pulse, then compare against the oldest expectation.
  task automatic wait_start(input string tag);
    exp_t e;
    int k = 0;
    while (!recovery_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_start"}, 32'(recovery_start), 32'd1);
    if (recovery_start) begin
      if (sb.size() == 0) chk({tag, "_sb_has_entry"}, 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk({tag, "_phase"}, 32'(phase), 32'd1);
        chk({tag, "_pc"}, recovered_pc, e.pc);
        chk({tag, "_fhead"}, 32'(flush_head_ptr), 32'(e.fh));
        chk({tag, "_ftail"}, 32'(flush_tail_ptr), 32'(e.ft));
        chk({tag, "_src"}, 32'(winner_src), 32'(e.src));
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_start"}, 32'(recovery_start), 32'd0);
    chk({tag, "_rpc"}, recovered_pc, 32'd0);
    chk({tag, "_fh"}, 32'(flush_head_ptr), 32'd0);
    chk({tag, "_ft"}, 32'(flush_tail_ptr), 32'd0);
    chk({tag, "_src"}, 32'(winner_src), 32'd0);
    chk({tag, "_trap"}, 32'(csr_trap_req), 32'd0);
    chk({tag, "_cause"}, csr_cause_pc, 32'd0);
    chk({tag, "_unable"}, 32'(unable_to_start), 32'd0);
    chk({tag, "_done"}, 32'(recovery_done), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(negedge clk);
    chk_idle("rst");
    rst = 1'b0;

    // single NEXT_PC from src1
    al_head_ptr = 6'd0; al_tail_ptr = 6'd9;
    set_req(1, 5, 32'h1000, 1);
    push(32'h1004, 6, 9, 1);
    #1 chk("t1_unable", 32'(unable_to_start), 32'd0);
    @(negedge clk);
    req_valid = '0;
    wait_start("t1");
    @(negedge clk);
    chk("t1_r1", 32'(phase), 32'd2);
    chk("t1_done", 32'(recovery_done), 32'd1);
    chk("t1_fh_r1", 32'(flush_head_ptr), 32'd6);
    @(negedge clk);
    chk("t1_commit", 32'(phase), 32'd0);
    chk("t1_fh_zero", 32'(flush_head_ptr), 32'd0);

    // age arbitration across wrap; loser held and accepted afterwards
    al_head_ptr = 6'd60; al_tail_ptr = 6'd20;
    set_req(0, 2, 32'h300, 0);
    set_req(1, 62, 32'h400, 2);
    push(32'h400, 63, 20, 1);
    push(32'h300, 2, 20, 0);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_start("t2a");
    @(negedge clk);
    wait_start("t2b");
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("t2_commit", 32'(phase), 32'd0);

    // THIS_PC_TO_CSR with a 3-cycle CSR_WAIT
    al_head_ptr = 6'd0; al_tail_ptr = 6'd12;
    set_req(0, 3, 32'h2000, 3);
    push(32'h80, 3, 12, 0);
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_phase", 32'(phase), 32'd3);
      chk("t3_trap", 32'(csr_trap_req), 32'd1);
      chk("t3_cause", csr_cause_pc, 32'h2000);
      if (i == 2) begin csr_trap_ack = 1'b1; csr_target_pc = 32'h80; end
      @(negedge clk);
    end
    csr_trap_ack = 1'b0;
    chk("t3_trap_off", 32'(csr_trap_req), 32'd0);
    wait_start("t3");
    repeat (2) @(negedge clk);
    chk("t3_commit", 32'(phase), 32'd0);

    // busy holds RECOVER_1; a new request is ignored meanwhile
    al_tail_ptr = 6'd30;
    set_req(1, 10, 32'h500, 0);
    push(32'h500, 10, 30, 1);
    @(negedge clk);
    req_valid = '0;
    wait_start("t4");
    busy = 4'b0100;
    set_req(0, 1, 32'h600, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_phase", 32'(phase), 32'd2);
      chk("t4_unable", 32'(unable_to_start), 32'd1);
      chk("t4_done", 32'(recovery_done), 32'd0);
    end
    req_valid = '0;
    busy = '0;
    #1 chk("t4_done_fall", 32'(recovery_done), 32'd1);
    @(negedge clk);
    chk("t4_commit", 32'(phase), 32'd0);
    chk("t4_tmo", 32'(timeout_err), 32'd0);
    chk("t4_nostart", 32'(recovery_start), 32'd0);

    // busy stuck: timeout at r1cnt==8, sticky until reset
    set_req(1, 10, 32'h500, 0);
    push(32'h500, 10, 30, 1);
    @(negedge clk);
    req_valid = '0;
    wait_start("t5");
    busy = 4'b0001;
    @(negedge clk);
    repeat (6) @(negedge clk);
    chk("t5_tmo_early", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    chk("t5_tmo_set", 32'(timeout_err), 32'd1);
    chk("t5_phase", 32'(phase), 32'd2);
    repeat (4) @(negedge clk);
    chk("t5_tmo_sticky", 32'(timeout_err), 32'd1);
    rst = 1'b1; busy = '0;
    @(negedge clk);
    chk_idle("t5_rst");
    rst = 1'b0;

    // reset during CSR_WAIT abandons the trap; late ack is ignored
    al_tail_ptr = 6'd5;
    set_req(0, 7, 32'h3000, 4);
    @(negedge clk);
    req_valid = '0;
    chk("t6_phase", 32'(phase), 32'd3);
    chk("t6_trap", 32'(csr_trap_req), 32'd1);
    chk("t6_cause", csr_cause_pc, 32'h3000);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_phase", 32'(phase), 32'd0);
    chk("t6_rst_trap", 32'(csr_trap_req), 32'd0);
    rst = 1'b0;
    csr_trap_ack = 1'b1; csr_target_pc = 32'h999;
    @(negedge clk);
    csr_trap_ack = 1'b0;
    chk("t6_late_phase", 32'(phase), 32'd0);
    chk("t6_late_start", 32'(recovery_start), 32'd0);
    @(negedge clk);
    chk("t6_still_commit", 32'(phase), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
